apb_bus_arbiter: RTL and testbench

- Two-requester scheduler in front of the single APB master request interface (transfer/write/addr/wdata/rdata/ready).
- Lets the CPU data bus (req0) and a second bus initiator (req1, e.g. DMA or debug loader) share the APB master and all peripherals behind it.
- Round-robin grant, latched command, one outstanding transfer.
- Watchdog aborts transfers whose slave never asserts ready.

---
 rtl/apb_bus_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_apb_bus_arbiter.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_bus_arbiter.sv
// Two-requester round-robin front end for a single APB master request port.
// One outstanding transfer, latched command, watchdog abort for hung slaves.
`timescale 1ns/1ps
module apb_bus_arbiter #(
   parameter int unsigned ADDR_W  = 32,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic              PCLK,
   input  logic              PRESET,
   input  logic              req0_transfer,
   input  logic              req0_write,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [DATA_W-1:0] req0_wdata,
   output logic [DATA_W-1:0] req0_rdata,
   output logic              req0_ready,
   output logic              req0_err,
   input  logic              req1_transfer,
   input  logic              req1_write,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [DATA_W-1:0] req1_wdata,
   output logic [DATA_W-1:0] req1_rdata,
   output logic              req1_ready,
   output logic              req1_err,
   output logic              m_transfer,
   output logic              m_write,
   output logic [ADDR_W-1:0] m_addr,
   output logic [DATA_W-1:0] m_wdata,
   input  logic [DATA_W-1:0] m_rdata,
   input  logic              m_ready,
   output logic              m_abort
);

   localparam int unsigned WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

   state_t            state_q, state_d;
   logic              ptr_q, ptr_d;     // requester that wins a tie
   logic              gnt_q, gnt_d;
   logic [1:0]        mask_q, mask_d;   // requester completed last cycle
   logic [WD_W-1:0]   wd_q, wd_d;

   logic              m_transfer_q, m_transfer_d;
   logic              m_write_q, m_write_d;
   logic [ADDR_W-1:0] m_addr_q, m_addr_d;
   logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
   logic              m_abort_q, m_abort_d;
   logic [DATA_W-1:0] req0_rdata_q, req0_rdata_d;
   logic [DATA_W-1:0] req1_rdata_q, req1_rdata_d;
   logic              req0_ready_q, req0_ready_d;
   logic              req1_ready_q, req1_ready_d;
   logic              req0_err_q, req0_err_d;
   logic              req1_err_q, req1_err_d;

   logic [1:0]        elig_c;
   logic              pick_c;
   logic [WD_W-1:0]   wd_inc_c;
   logic              wd_exp_c;

   // Next-state and registered-output computation
   always_comb begin
      state_d      = state_q;
      ptr_d        = ptr_q;
      gnt_d        = gnt_q;
      mask_d       = 2'b00;
      wd_d         = wd_q;
      m_transfer_d = 1'b0;
      m_write_d    = m_write_q;
      m_addr_d     = m_addr_q;
      m_wdata_d    = m_wdata_q;
      m_abort_d    = 1'b0;
      req0_rdata_d = req0_rdata_q;
      req1_rdata_d = req1_rdata_q;
      req0_ready_d = 1'b0;
      req1_ready_d = 1'b0;
      req0_err_d   = 1'b0;
      req1_err_d   = 1'b0;

      elig_c   = {req1_transfer, req0_transfer} & ~mask_q;
      pick_c   = (elig_c == 2'b11) ? ptr_q : elig_c[1];
      wd_inc_c = wd_q + WD_W'(1);
      wd_exp_c = (TIMEOUT != 0) && (wd_inc_c == WD_W'(TIMEOUT));

      case (state_q)
         IDLE: begin
            if (elig_c != 2'b00) begin
               gnt_d        = pick_c;
               m_transfer_d = 1'b1;
               m_write_d    = pick_c ? req1_write : req0_write;
               m_addr_d     = pick_c ? req1_addr  : req0_addr;
               m_wdata_d    = pick_c ? req1_wdata : req0_wdata;
               state_d      = ISSUE;
            end
         end
         ISSUE: begin
            wd_d    = '0;
            state_d = WAIT;
         end
         WAIT: begin
            // A late m_ready still beats the watchdog in the same cycle
            if (m_ready) begin
               state_d = DONE;
               if (gnt_q) begin
                  req1_ready_d = 1'b1;
                  if (!m_write_q) req1_rdata_d = m_rdata;
               end else begin
                  req0_ready_d = 1'b1;
                  if (!m_write_q) req0_rdata_d = m_rdata;
               end
            end else begin
               if (TIMEOUT != 0) wd_d = wd_inc_c;
               if (wd_exp_c) begin
                  state_d    = DONE;
                  m_abort_d  = 1'b1;
                  req0_err_d = ~gnt_q;
                  req1_err_d = gnt_q;
               end
            end
         end
         DONE: begin
            ptr_d   = ~gnt_q;
            mask_d  = gnt_q ? 2'b10 : 2'b01;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK or negedge PRESET) begin
      if (!PRESET) begin
         state_q      <= IDLE;
         ptr_q        <= 1'b0;
         gnt_q        <= 1'b0;
         mask_q       <= 2'b00;
         wd_q         <= '0;
         m_transfer_q <= 1'b0;
         m_write_q    <= 1'b0;
         m_addr_q     <= '0;
         m_wdata_q    <= '0;
         m_abort_q    <= 1'b0;
         req0_rdata_q <= '0;
         req1_rdata_q <= '0;
         req0_ready_q <= 1'b0;
         req1_ready_q <= 1'b0;
         req0_err_q   <= 1'b0;
         req1_err_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         ptr_q        <= ptr_d;
         gnt_q        <= gnt_d;
         mask_q       <= mask_d;
         wd_q         <= wd_d;
         m_transfer_q <= m_transfer_d;
         m_write_q    <= m_write_d;
         m_addr_q     <= m_addr_d;
         m_wdata_q    <= m_wdata_d;
         m_abort_q    <= m_abort_d;
         req0_rdata_q <= req0_rdata_d;
         req1_rdata_q <= req1_rdata_d;
         req0_ready_q <= req0_ready_d;
         req1_ready_q <= req1_ready_d;
         req0_err_q   <= req0_err_d;
         req1_err_q   <= req1_err_d;
      end
   end

   assign m_transfer = m_transfer_q;
   assign m_write    = m_write_q;
   assign m_addr     = m_addr_q;
   assign m_wdata    = m_wdata_q;
   assign m_abort    = m_abort_q;
   assign req0_rdata = req0_rdata_q;
   assign req1_rdata = req1_rdata_q;
   assign req0_ready = req0_ready_q;
   assign req1_ready = req1_ready_q;
   assign req0_err   = req0_err_q;
   assign req1_err   = req1_err_q;

endmodule

// File: tb/tb_apb_bus_arbiter.sv
// Scoreboard bench for apb_bus_arbiter: requester drivers, APB slave model,
// expected bus commands and completions queued in grant order.
`timescale 1ns/1ps
module tb_apb_bus_arbiter;

   localparam int unsigned TIMEOUT = 16;

   typedef struct {
      int          id;
      logic        write;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          delay;     // WAIT cycle of m_ready, 0 = never
      bit          scramble;  // requester trashes wdata after grant
      int          lat;       // expected load->m_transfer cycles, -1 = skip
   } cmd_t;

   typedef struct {
      int          id;
      bit          err;
      logic        write;
      logic [31:0] addr;
      int          delay;
   } cpl_t;

   logic        PCLK, PRESET;
   logic        rq_transfer [2];
   logic        rq_write    [2];
   logic [31:0] rq_addr     [2];
   logic [31:0] rq_wdata    [2];
   logic [31:0] rq_rdata    [2];
   logic        rq_ready    [2];
   logic        rq_err      [2];
   logic        m_transfer, m_write, m_abort, m_ready;
   logic [31:0] m_addr, m_wdata, m_rdata;

   int   checks = 0;
   int   passed = 0;
   int   cyc = 0;
   int   t_req [2];
   int   t_iss = 0;
   bit   drop [2];

   cmd_t req_pend [$];
   cmd_t exp_bus  [$];
   cpl_t exp_cpl  [$];
   logic [31:0] exp_rd [2];

   cmd_t s_cur;
   bit   s_active = 0;
   int   s_cnt = 0;

   apb_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TIMEOUT)) dut (
      .PCLK(PCLK), .PRESET(PRESET),
      .req0_transfer(rq_transfer[0]), .req0_write(rq_write[0]), .req0_addr(rq_addr[0]),
      .req0_wdata(rq_wdata[0]), .req0_rdata(rq_rdata[0]), .req0_ready(rq_ready[0]),
      .req0_err(rq_err[0]),
      .req1_transfer(rq_transfer[1]), .req1_write(rq_write[1]), .req1_addr(rq_addr[1]),
      .req1_wdata(rq_wdata[1]), .req1_rdata(rq_rdata[1]), .req1_ready(rq_ready[1]),
      .req1_err(rq_err[1]),
      .m_transfer(m_transfer), .m_write(m_write), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .m_ready(m_ready), .m_abort(m_abort)
   );

   initial PCLK = 1'b0;
   always #5 PCLK = ~PCLK;
   always @(posedge PCLK) cyc <= cyc + 1;

   task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
      checks++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
   endtask

   function automatic logic [31:0] rd_val(input logic [31:0] a);
      if (a == 32'h1000_2004) return 32'h0000_00A5;
      return a ^ 32'h5A5A_0000;
   endfunction

   function automatic logic [4:0] cpl_flags(input int id, input bit err);
      if (id == 0) return err ? 5'b01001 : 5'b10000;
      return err ? 5'b00011 : 5'b00100;
   endfunction

   // Queue one transfer; call order defines the expected grant order
   task automatic send(input int id, input logic wr, input logic [31:0] a, input logic [31:0] d,
                       input int delay, input bit scr, input int lat);
      cmd_t c;
      cpl_t e;
      c = '{id, wr, a, d, delay, scr, lat};
      e = '{id, (delay == 0) || (delay > int'(TIMEOUT)), wr, a, delay};
      req_pend.push_back(c);
      exp_bus.push_back(c);
      exp_cpl.push_back(e);
   endtask

   // Requesters: hold until ready/err, then drop or load the next command
   always @(posedge PCLK) begin
      #1;
      for (int i = 0; i < 2; i++) begin
         if (!PRESET) begin
            rq_transfer[i] = 1'b0;
            rq_write[i]    = 1'b0;
            rq_addr[i]     = '0;
            rq_wdata[i]    = '0;
            drop[i]        = 1'b0;
         end else begin
            if (drop[i]) begin
               rq_transfer[i] = 1'b0;
               drop[i]        = 1'b0;
            end
            if (!rq_transfer[i]) begin
               for (int k = 0; k < req_pend.size(); k++) begin
                  if (req_pend[k].id == i) begin
                     rq_write[i]    = req_pend[k].write;
                     rq_addr[i]     = req_pend[k].addr;
                     rq_wdata[i]    = req_pend[k].wdata;
                     rq_transfer[i] = 1'b1;
                     t_req[i]       = cyc;
                     req_pend.delete(k);
                     break;
                  end
               end
            end else if (cyc - t_req[i] >= 2 && rq_write[i] && rq_wdata[i] == 32'hDEAD_BEEF) begin
               rq_wdata[i] = '0;
            end
            if (rq_ready[i] || rq_err[i]) drop[i] = 1'b1;
         end
      end
   end

   // APB slave model: checks the issued command and its stability, answers m_ready
   always @(posedge PCLK) begin
      #1;
      m_ready = 1'b0;
      if (!PRESET) begin
         s_active = 0;
         m_rdata  = '0;
      end else begin
         if (s_active) begin
            if (m_abort) s_active = 0;
            else begin
               check_eq("m_hold", {m_write, m_addr, m_wdata}, {s_cur.write, s_cur.addr, s_cur.wdata});
               s_cnt++;
               if (s_cur.delay != 0 && s_cnt == s_cur.delay) begin
                  m_ready  = 1'b1;
                  m_rdata  = rd_val(s_cur.addr);
                  s_active = 0;
               end
            end
         end
         if (m_transfer) begin
            if (exp_bus.size() == 0) check_eq("bus_unexpected", {m_write, m_addr}, 0);
            else begin
               s_cur = exp_bus.pop_front();
               check_eq("bus_cmd", {m_write, m_addr, m_wdata}, {s_cur.write, s_cur.addr, s_cur.wdata});
               if (s_cur.lat >= 0) check_eq("issue_lat", cyc - t_req[s_cur.id], s_cur.lat);
               s_active = 1;
               s_cnt    = 0;
               t_iss    = cyc;
            end
         end
      end
   end

   // Completion scoreboard
   always @(negedge PCLK) begin
      cpl_t e;
      if (PRESET && (rq_ready[0] || rq_err[0] || rq_ready[1] || rq_err[1] || m_abort)) begin
         if (exp_cpl.size() == 0)
            check_eq("cpl_unexpected", {rq_ready[0], rq_err[0], rq_ready[1], rq_err[1], m_abort}, 0);
         else begin
            e = exp_cpl.pop_front();
            check_eq("cpl_flags", {rq_ready[0], rq_err[0], rq_ready[1], rq_err[1], m_abort},
                     cpl_flags(e.id, e.err));
            if (!e.err && !e.write) exp_rd[e.id] = rd_val(e.addr);
            check_eq("rdata0", rq_rdata[0], exp_rd[0]);
            check_eq("rdata1", rq_rdata[1], exp_rd[1]);
            check_eq("cpl_lat", cyc - t_iss, e.err ? int'(TIMEOUT) + 1 : e.delay + 1);
         end
      end
   end

   task automatic check_outs_zero(input string tag);
      check_eq({tag, "_req"}, {rq_rdata[0], rq_rdata[1], rq_ready[0], rq_err[0], rq_ready[1], rq_err[1]}, 0);
      check_eq({tag, "_m"}, {m_transfer, m_write, m_addr, m_wdata, m_abort}, 0);
   endtask

   task automatic do_reset();
      @(negedge PCLK);
      PRESET = 1'b0;
      #1;
      check_outs_zero("rst");
      req_pend.delete();
      exp_bus.delete();
      exp_cpl.delete();
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      repeat (2) @(negedge PCLK);
      PRESET = 1'b1;
   endtask

   task automatic wait_drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         @(negedge PCLK);
         if (exp_cpl.size() == 0) break;
      end
      check_eq("drain", exp_cpl.size(), 0);
      repeat (3) @(negedge PCLK);
   endtask

   initial begin
      bit seen;
      PRESET    = 1'b0;
      exp_rd[0] = '0;
      exp_rd[1] = '0;
      repeat (3) @(posedge PCLK);
      #2;
      check_outs_zero("init");
      @(negedge PCLK);
      PRESET = 1'b1;

      // Uncontended read with minimum latency
      send(0, 1'b0, 32'h1000_2004, 32'h0, 1, 0, 1);
      wait_drain(50);

      // Contended traffic must alternate starting with req0
      do_reset();
      send(0, 1'b0, 32'h1000_0010, 32'h0, 1, 0, 1);
      send(1, 1'b0, 32'h1000_0020, 32'h0, 2, 0, -1);
      send(0, 1'b1, 32'h1000_0030, 32'h1234_5678, 1, 0, -1);
      send(1, 1'b0, 32'h1000_0040, 32'h0, 1, 0, -1);
      wait_drain(100);

      // Write whose wdata changes after grant
      send(1, 1'b1, 32'h1000_3000, 32'hDEAD_BEEF, 4, 1, 1);
      wait_drain(50);

      // Watchdog abort followed by a normal grant to the waiting requester
      send(0, 1'b0, 32'h2000_0000, 32'h0, 0, 0, 1);
      send(1, 1'b0, 32'h2000_0004, 32'h0, 1, 0, -1);
      wait_drain(100);

      // m_ready on the expiry cycle beats the watchdog
      send(0, 1'b0, 32'h2000_0008, 32'h0, 16, 0, 1);
      wait_drain(100);

      // Reset in the middle of WAIT
      send(0, 1'b0, 32'h3000_0000, 32'h0, 0, 0, 1);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge PCLK);
         if (m_transfer) begin
            seen = 1;
            break;
         end
      end
      check_eq("rst_issue_seen", seen, 1);
      repeat (3) @(negedge PCLK);
      do_reset();
      send(0, 1'b0, 32'h3000_0010, 32'h0, 1, 0, 1);
      send(1, 1'b0, 32'h3000_0020, 32'h0, 1, 0, -1);
      wait_drain(100);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
